// File: rtl/quad_pkg.sv
// Shared types and phase tables for the quadrature transmitter.
// Index 0 is the first phase driven after leaving rest; index 3 returns to rest.
package quad_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  localparam logic [1:0] REST = 2'b00;

  // Packed {entry3, entry2, entry1, entry0}; each entry is {A, B}
  localparam logic [3:0][1:0] CW_TABLE  = {2'b00, 2'b01, 2'b11, 2'b10};
  localparam logic [3:0][1:0] CCW_TABLE = {2'b00, 2'b10, 2'b11, 2'b01};

  function automatic logic [1:0] phase_ab(input logic dir, input logic [1:0] idx);
    return (dir == DIR_CW) ? CW_TABLE[idx] : CCW_TABLE[idx];
  endfunction

endpackage

// File: rtl/quad_phase_timer.sv
// Phase hold timer: strobes phase_end on the last clock of each phase and
// rolls over on that same clock. Held at zero while clear is high.
module quad_phase_timer #(
  parameter int PHASE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic phase_end
);

  localparam int CNT_W = $clog2(PHASE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg;

  assign phase_end = !clear && (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear || phase_end) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + ONE;
    end
  end

endmodule

// File: rtl/quadrature_tx.sv
// Quadrature transmitter: turns (direction, detent count) commands into a
// Gray-coded A/B waveform and tracks a signed running detent position.
module quadrature_tx
  import quad_pkg::*;
#(
  parameter int PHASE_CYCLES = 4,
  parameter int STEP_W       = 8,
  parameter int POS_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [STEP_W-1:0]       cmd_steps,
  input  logic                    abort,
  output logic                    rot_a,
  output logic                    rot_b,
  output logic                    busy,
  output logic                    cmd_done,
  output logic signed [POS_W-1:0] position
);

  localparam logic [STEP_W-1:0]       STEP_ONE = STEP_W'(1);
  localparam logic signed [POS_W-1:0] POS_ONE  = POS_W'(1);

  state_t                    state_reg, state_next;
  logic [1:0]                idx_reg, idx_next;
  logic [STEP_W-1:0]         rem_reg, rem_next;
  logic                      dir_reg, dir_next;
  logic                      abort_reg, abort_next;
  logic signed [POS_W-1:0]   pos_reg, pos_next;
  logic [1:0]                rot_reg, rot_next;
  logic                      done_reg, done_next;
  logic                      abort_pending;
  logic                      phase_end;

  quad_phase_timer #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_reg == IDLE),
    .phase_end(phase_end)
  );

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    rem_next      = rem_reg;
    dir_next      = dir_reg;
    abort_next    = abort_reg;
    pos_next      = pos_reg;
    rot_next      = rot_reg;
    done_next     = 1'b0;
    abort_pending = abort_reg | abort;

    case (state_reg)
      IDLE: begin
        rot_next   = REST;
        abort_next = 1'b0;
        if (cmd_valid) begin
          if (cmd_steps == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = RUN;
            dir_next   = cmd_dir;
            rem_next   = cmd_steps;
            idx_next   = 2'd0;
            rot_next   = phase_ab(cmd_dir, 2'd0);
          end
        end
      end

      RUN: begin
        abort_next = abort_pending;
        if (phase_end) begin
          if (idx_reg != 2'd3) begin
            idx_next = idx_reg + 2'd1;
            rot_next = phase_ab(dir_reg, idx_reg + 2'd1);
          end else begin
            // Rest phase finished: the detent is complete
            pos_next = (dir_reg == DIR_CW) ? pos_reg + POS_ONE : pos_reg - POS_ONE;
            rem_next = rem_reg - STEP_ONE;
            if (rem_reg != STEP_ONE && !abort_pending) begin
              idx_next = 2'd0;
              rot_next = phase_ab(dir_reg, 2'd0);
            end else begin
              state_next = IDLE;
              done_next  = 1'b1;
              abort_next = 1'b0;
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= 2'd0;
      rem_reg   <= '0;
      dir_reg   <= DIR_CW;
      abort_reg <= 1'b0;
      pos_reg   <= '0;
      rot_reg   <= REST;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      rem_reg   <= rem_next;
      dir_reg   <= dir_next;
      abort_reg <= abort_next;
      pos_reg   <= pos_next;
      rot_reg   <= rot_next;
      done_reg  <= done_next;
    end
  end

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg == RUN);
  assign rot_a     = rot_reg[1];
  assign rot_b     = rot_reg[0];
  assign cmd_done  = done_reg;
  assign position  = pos_reg;

endmodule

// File: tb/tb_quadrature_tx.sv
// Scoreboard bench for quadrature_tx: a PHASE_CYCLES=4/POS_W=16 instance for the
// main scenarios and a PHASE_CYCLES=1/POS_W=4 instance for wrap and fast stepping.
module tb_quadrature_tx;

  localparam int PC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0;
  logic [7:0]  cmd_steps = '0;
  logic        cmd_ready, rot_a, rot_b, busy, cmd_done;
  logic [15:0] position;

  logic        b_valid = 1'b0, b_dir = 1'b0, b_abort = 1'b0;
  logic [7:0]  b_steps = '0;
  logic        b_ready, b_rot_a, b_rot_b, b_busy, b_done;
  logic [3:0]  b_pos;

  quadrature_tx #(.PHASE_CYCLES(PC), .STEP_W(8), .POS_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .abort(abort),
    .rot_a(rot_a), .rot_b(rot_b), .busy(busy), .cmd_done(cmd_done),
    .position(position)
  );

  quadrature_tx #(.PHASE_CYCLES(1), .STEP_W(8), .POS_W(4)) dut_fast (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_dir(b_dir), .cmd_steps(b_steps), .abort(b_abort),
    .rot_a(b_rot_a), .rot_b(b_rot_b), .busy(b_busy), .cmd_done(b_done),
    .position(b_pos)
  );

  int errors = 0;
  int checks = 0;

  logic [1:0] cw_seq  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] ccw_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  typedef struct {
    logic [1:0]  rot;
    logic [15:0] pos;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] pos_model = '0;
  logic [3:0]  bpos_model = '0;

  // Gray legality on both instances: a change may never flip A and B together
  logic [1:0] prev_a = 2'b00, prev_b = 2'b00;
  always @(negedge clk) begin
    if (rst_n) begin
      if ({rot_a, rot_b} != prev_a) begin
        checks++;
        if (({rot_a, rot_b} ^ prev_a) == 2'b11) begin
          errors++;
          $display("FAIL gray_main: got %b after %b, required single-bit change", {rot_a, rot_b}, prev_a);
        end
      end
      if ({b_rot_a, b_rot_b} != prev_b) begin
        checks++;
        if (({b_rot_a, b_rot_b} ^ prev_b) == 2'b11) begin
          errors++;
          $display("FAIL gray_fast: got %b after %b, required single-bit change", {b_rot_a, b_rot_b}, prev_b);
        end
      end
    end
    prev_a = {rot_a, rot_b};
    prev_b = {b_rot_a, b_rot_b};
  end

  // One command on the main instance, scored cycle by cycle against exp_q
  task automatic run_cmd(input string name, input logic dir, input int steps,
                         input int abort_at, input bit hold_valid);
    exp_t        e;
    int          n_det;
    int          k;
    logic [15:0] dpos;
    dpos  = dir ? 16'd1 : 16'hFFFF;
    n_det = steps;
    if (abort_at >= 0 && (abort_at / (4 * PC)) + 1 < steps) n_det = abort_at / (4 * PC) + 1;
    for (int i = 0; i < n_det * 4 * PC; i++) begin
      e.rot = dir ? cw_seq[(i / PC) % 4] : ccw_seq[(i / PC) % 4];
      e.pos = pos_model + dpos * 16'(i / (4 * PC));
      exp_q.push_back(e);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got %b required 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_dir = dir; cmd_steps = 8'(steps);
    @(posedge clk); #1;
    cmd_valid = hold_valid; cmd_dir = ~dir; cmd_steps = 8'd7;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({rot_a, rot_b} !== e.rot) begin
        errors++;
        $display("FAIL %s rot cycle %0d: got %b required %b", name, k, {rot_a, rot_b}, e.rot);
      end
      checks++;
      if (position !== e.pos) begin
        errors++;
        $display("FAIL %s position cycle %0d: got %h required %h", name, k, position, e.pos);
      end
      checks++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1 || cmd_done !== 1'b0) begin
        errors++;
        $display("FAIL %s run_flags cycle %0d: got ready=%b busy=%b done=%b required 0 1 0",
                 name, k, cmd_ready, busy, cmd_done);
      end
      abort = (k == abort_at);
      k++;
    end
    @(negedge clk);
    abort = 1'b0; cmd_valid = 1'b0;
    pos_model = pos_model + dpos * 16'(n_det);
    checks++;
    if (cmd_done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_pulse: got %b required 1", name, cmd_done);
    end
    checks++;
    if ({rot_a, rot_b} !== 2'b00 || position !== pos_model) begin
      errors++;
      $display("FAIL %s final: got rot=%b pos=%h required rot=00 pos=%h", name, {rot_a, rot_b}, position, pos_model);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_flags: got ready=%b busy=%b required 1 0", name, cmd_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (cmd_done !== 1'b0 || cmd_ready !== 1'b1 || position !== pos_model) begin
      errors++;
      $display("FAIL %s after_done: got done=%b ready=%b pos=%h required 0 1 %h",
               name, cmd_done, cmd_ready, position, pos_model);
    end
    $display("%s: dir=%0d steps=%0d detents=%0d position=%0d", name, dir, steps, n_det, $signed(position));
  endtask

  // One command on the fast instance (one clock per phase, 4-bit position)
  task automatic run_b(input string name, input logic dir, input int steps);
    logic [1:0] bq[$];
    logic [1:0] want;
    for (int i = 0; i < steps * 4; i++) bq.push_back(dir ? cw_seq[i % 4] : ccw_seq[i % 4]);
    @(negedge clk);
    checks++;
    if (b_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got %b required 1", name, b_ready);
    end
    b_valid = 1'b1; b_dir = dir; b_steps = 8'(steps);
    @(posedge clk); #1;
    b_valid = 1'b0;
    while (bq.size() > 0) begin
      @(negedge clk);
      want = bq.pop_front();
      checks++;
      if ({b_rot_a, b_rot_b} !== want || b_done !== 1'b0) begin
        errors++;
        $display("FAIL %s rot: got %b done=%b required %b done=0", name, {b_rot_a, b_rot_b}, b_done, want);
      end
    end
    @(negedge clk);
    if (dir) bpos_model = bpos_model + 4'(steps);
    else     bpos_model = bpos_model - 4'(steps);
    checks++;
    if (b_done !== 1'b1 || b_pos !== bpos_model || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s final: got done=%b pos=%h ready=%b required 1 %h 1", name, b_done, b_pos, b_ready, bpos_model);
    end
    $display("%s: dir=%0d steps=%0d position=%0d", name, dir, steps, $signed(b_pos));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rot_a, rot_b} !== 2'b00 || position !== 16'h0 || cmd_ready !== 1'b1 || busy !== 1'b0 || cmd_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rot=%b pos=%h ready=%b busy=%b done=%b required 00 0000 1 0 0",
               {rot_a, rot_b}, position, cmd_ready, busy, cmd_done);
    end
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rot_a, rot_b} !== 2'b00 || cmd_ready !== 1'b1 || busy !== 1'b0 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: got rot=%b ready=%b busy=%b b_ready=%b required 00 1 0 1",
               {rot_a, rot_b}, cmd_ready, busy, b_ready);
    end
    $display("reset: rot=%b position=%0d ready=%b", {rot_a, rot_b}, $signed(position), cmd_ready);
  endtask

  task automatic test_reset_mid_detent();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd3;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (22) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rot_a, rot_b} !== 2'b00 || busy !== 1'b0 || cmd_ready !== 1'b1 || position !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_detent: got rot=%b busy=%b ready=%b pos=%h required 00 0 1 0000",
               {rot_a, rot_b}, busy, cmd_ready, position);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    pos_model = '0;
    $display("reset_mid_detent: rot=%b position=%0d", {rot_a, rot_b}, $signed(position));
  endtask

  task automatic test_cw_two();
    run_cmd("cw_two", 1'b1, 2, -1, 1'b0);
  endtask

  task automatic test_ccw_three();
    run_cmd("ccw_three", 1'b0, 3, -1, 1'b0);
    checks++;
    if (position !== 16'hFFFD) begin
      errors++;
      $display("FAIL ccw_three_pos: got %h required fffd", position);
    end
  endtask

  task automatic test_abort();
    // cycle 21 lies in the second phase of the second detent
    run_cmd("abort", 1'b1, 5, 21, 1'b0);
  endtask

  task automatic test_zero_and_idle_abort();
    run_cmd("zero_steps", 1'b1, 0, -1, 1'b0);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    run_cmd("after_idle_abort", 1'b0, 2, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_cmd("busy_holdoff", 1'b1, 1, -1, 1'b1);
  endtask

  task automatic test_wrap_fast();
    run_b("fast_cw7", 1'b1, 7);
    run_b("fast_wrap_up", 1'b1, 1);
    checks++;
    if (b_pos !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_up: got %b required 1000", b_pos);
    end
    run_b("fast_wrap_down", 1'b0, 1);
    checks++;
    if (b_pos !== 4'b0111) begin
      errors++;
      $display("FAIL wrap_down: got %b required 0111", b_pos);
    end
    run_b("fast_ccw3", 1'b0, 3);
  endtask

  initial begin
    test_reset();
    test_cw_two();
    test_reset_mid_detent();
    test_ccw_three();
    test_abort();
    test_zero_and_idle_abort();
    test_back_to_back();
    test_wrap_fast();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/quadrature_tx.md
Name: quadrature_tx

Overview:
Quadrature transmitter: converts step commands (direction + detent count) into a two-phase Gray-coded ROT_A/ROT_B waveform. It emits exactly what a rotary-encoder receiver such as the LED rotator expects, and serves as the board-level stimulus source and loopback generator for encoder-driven blocks. It sits between a command source (switch/button logic or test controller) and any quadrature input.

Parameters:
PHASE_CYCLES, 4, clocks each quadrature phase is held (legal range 1 or more)
STEP_W, 8, width of the per-command detent count
POS_W, 16, width of the signed running position counter

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
CMD_VALID  in  1  command offered
CMD_READY  out  1  high exactly when in IDLE; command accepted on the CMD_VALID && CMD_READY cycle
CMD_DIR  in  1  1 = clockwise (A leads), 0 = counter-clockwise (B leads); sampled at acceptance
CMD_STEPS  in  STEP_W  number of detents; sampled at acceptance
ABORT  in  1  stop at the next detent boundary
ROT_A  out  1  quadrature phase A, registered
ROT_B  out  1  quadrature phase B, registered
BUSY  out  1  high in RUN
CMD_DONE  out  1  one-cycle pulse when a command finishes
POSITION  out  POS_W  signed detent count: +1 per CW detent, -1 per CCW detent

Behaviour:
- Reset (asynchronous, any time, including mid-detent):
  - State IDLE; ROT_A = ROT_B = 0; POSITION = 0; BUSY = 0; CMD_DONE = 0; CMD_READY = 1.
  - Timer, remaining count and abort flag are cleared.
- Rest state is {A,B} = 00.
- CW detent phase order: 10, 11, 01, 00. CCW detent phase order: 01, 11, 10, 00.
- Exactly one output bit changes per transition. Never allowed: a double change, or any output change other than at a phase boundary.
- FSM states: IDLE, RUN.
- IDLE:
  - Outputs are 00.
  - On acceptance with CMD_STEPS = 0: stay in IDLE; CMD_DONE pulses on the next cycle; outputs do not move.
  - On acceptance with CMD_STEPS > 0: latch DIR and STEPS. The next cycle enters RUN with phase 1 already driven.
- RUN:
  - Each phase is held for exactly PHASE_CYCLES clocks; one detent therefore lasts 4*PHASE_CYCLES clocks.
  - At the end of phase 4 (00 held full time):
    - POSITION updates by ±1, two's-complement wrap (max+1 -> min, min-1 -> max).
    - Remaining count decrements.
  - If remaining > 0 and no abort is pending, phase 1 of the next detent is driven the very next cycle (no gap).
  - Otherwise: go to IDLE, pulse CMD_DONE on the same edge as the IDLE entry, and clear the abort flag.
- ABORT:
  - Sampled every RUN cycle and sets a sticky flag; the current detent always completes, so ROT never jumps to 00 mid-detent.
  - ABORT in IDLE is ignored.
  - ABORT coinciding with the final detent completion behaves identically to normal completion (single CMD_DONE).
- CMD_VALID while busy: held off by CMD_READY = 0. Inputs are not sampled.
- PHASE_CYCLES = 1: a phase change every clock, still Gray-legal.
- Latency: first output edge occurs 1 clock after acceptance.
- A, B, POSITION and CMD_DONE come from flops. CMD_READY and BUSY are decoded from the state register only.

Decomposition:
- Shared package quad_pkg:
  - State enum {IDLE, RUN}.
  - DIR_CW / DIR_CCW constants.
  - 4-entry phase table per direction, indexed by a 2-bit phase index.
  - REST constant 2'b00.
- Sub-module quad_phase_timer:
  - Counts 0..PHASE_CYCLES-1, width $clog2(PHASE_CYCLES+1).
  - Emits a phase_end strobe and rolls over on the same clock; cleared in IDLE.
- Top level holds: FSM, 2-bit phase index, remaining counter, abort flag, POSITION.

Test Plan:
- Reset then idle, CMD_VALID low -> ROT=00, POSITION=0, CMD_READY=1; assert RST_N low mid-detent -> outputs 00 and state IDLE immediately, without waiting for a clock.
- PHASE_CYCLES=4, CMD_DIR=1, CMD_STEPS=2 -> ROT sequence 10,11,01,00,10,11,01,00, each held 4 clocks (32 clocks total); POSITION 0->1->2; CMD_DONE single pulse on clock 33 after acceptance; CMD_READY low for exactly that window.
- CMD_DIR=0, CMD_STEPS=3 from POSITION=0 -> sequence 01,11,10,00 ×3, POSITION=-3 (0xFFFD for POS_W=16); checker flags any cycle where A and B change together.
- CMD_STEPS=5, ABORT pulsed for 1 clock during phase 2 of detent 2 -> detent 2 completes, POSITION=+2, CMD_DONE pulses, ROT=00, no detent 3 started.
- CMD_STEPS=0 accepted -> no ROT activity, CMD_DONE pulses 1 clock later; a new CMD_VALID offered while BUSY -> not accepted until IDLE, POSITION advanced only by the first command.
- POS_W=4, POSITION=7, one CW detent -> POSITION=-8 (wrap); PHASE_CYCLES=1 run -> phase change every clock with Gray check passing.
